axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed in WAIT_B/WAIT_R before abort; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  the single clock; every flop is on its rising edge.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  in  32  byte address, passed through unmodified.
REQ-008 SHALL have port cmd_wdata  in  32  write data.
REQ-009 SHALL have port cmd_wstrb  in  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-012 SHALL have port rsp_rdata  out  32  read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_resp  out  2  AXI response code (bresp/rresp), or 2'b11 on timeout.
REQ-014 SHALL have ports m_axi_awvalid out 1, m_axi_awaddr out 32, m_axi_awready in 1: write address channel.
REQ-015 SHALL have ports m_axi_wvalid out 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wready in 1: write data channel.
REQ-016 SHALL have ports m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1: write response channel.
REQ-017 SHALL have ports m_axi_arvalid out 1, m_axi_araddr out 32, m_axi_arready in 1: read address channel.
REQ-018 SHALL have ports m_axi_rvalid in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rready out 1: read data channel.

Function
REQ-019 SHALL implement states IDLE, WR, WAIT_B, RD, WAIT_R, RSP; one transaction outstanding at a time.
REQ-020 SHALL drive cmd_ready high only in IDLE, and only while rsp_valid is low.
REQ-021 SHALL capture addr/wdata/wstrb on cmd handshake and go to WR (cmd_write=1) or RD (cmd_write=0).
REQ-022 SHALL drive all AXI outputs from flops; awvalid/arvalid is first high on the cycle after cmd handshake.
REQ-023 WR: SHALL assert awvalid and wvalid together; each drops the cycle after its own handshake (independent aw_done/w_done flags); handshakes may be same-cycle or in either order; valids never drop before handshake.
REQ-024 SHALL go to WAIT_B once aw_done and w_done are both set; bready is high only in WAIT_B; on B handshake, latch bresp, go to RSP.
REQ-025 RD: arvalid held until handshake, then WAIT_R with rready high; on R handshake, latch rdata/rresp, go to RSP.
REQ-026 SHALL clear the timeout counter on entry to WAIT_B/WAIT_R and increment it every waiting cycle; at TIMEOUT_CYCLES, deassert bready/rready, set rsp_resp=2'b11, rsp_rdata=0, go to RSP.
REQ-027 SHALL hold rsp_valid high with stable data in RSP until rsp_ready; on handshake, go to IDLE; rsp_valid is first high on the cycle after the B/R handshake.
REQ-028 SHALL ignore bvalid/rvalid outside WAIT_B/WAIT_R; those responses are never latched.

Reset
REQ-029 On rst high at a clock edge, from any state including mid-transaction: go to IDLE; set every valid/ready output, aw_done/w_done, the counter, and all captured/response registers to 0 at that edge.

Structure
REQ-030 SHALL take response codes (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11) and the state encoding from shared package axi_lite_pkg.
REQ-031 SHALL need no sub-module; the timeout counter is implemented inline.

Verification
REQ-032 Write cmd 0x0000_0010/0xDEAD_BEEF/4'hF against a slave with awready in idle and wready one cycle later -> awvalid cycles 1-1, wvalid cycles 1-2, bready from cycle 3, rsp_resp=00, rsp_rdata=0.
REQ-033 Read cmd 0x0000_0020 against a slave returning 0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_resp=00; arvalid low after handshake.
REQ-034 Write with wready before awready (3-cycle skew) -> each valid drops individually; exactly one B accepted.
REQ-035 Read with rvalid never asserted, TIMEOUT_CYCLES=8 -> rready low after 8 wait cycles, rsp_resp=11, rsp_rdata=0.
REQ-036 rsp_ready held low 5 cycles -> rsp_valid/data stable, cmd_ready low; rst pulsed during WR -> all outputs 0 next edge, next command completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the command-master state encoding.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WAIT_B = 3'd2,
        RD     = 3'd3,
        WAIT_R = 3'd4,
        RSP    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A lost response is reported with the same code as a decode error.
    localparam logic [1:0] RESP_TIMEOUT = RESP_DECERR;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AW/W/B or AR/R
// transaction and returns the result on a valid/ready response port.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic        m_axi_awvalid,
    output logic [31:0] m_axi_awaddr,
    input  logic        m_axi_awready,

    output logic        m_axi_wvalid,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_wready,

    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_bready,

    output logic        m_axi_arvalid,
    output logic [31:0] m_axi_araddr,
    input  logic        m_axi_arready,

    input  logic        m_axi_rvalid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    output logic        m_axi_rready
);

    // The counter value seen on the last permitted waiting cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;

    logic aw_hs;
    logic w_hs;
    logic timeout_hit;

    // Commands are refused while reset is held so nothing is accepted mid-reset.
    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && !rst;

    assign aw_hs       = awvalid_q && m_axi_awready;
    assign w_hs        = wvalid_q && m_axi_wready;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD;
                    end
                end
            end

            // AW and W complete independently; leave once both have been taken.
            WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_B;
                end
            end

            WAIT_B: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = RSP;
                end else if (timeout_hit) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_TIMEOUT;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            RD: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_R;
                end
            end

            WAIT_R: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = RSP;
                end else if (timeout_hit) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_TIMEOUT;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a latency-configurable AXI-Lite slave plus
// directed and randomized commands checked against expected responses.
module tb_axi_lite_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;

    int checks   = 0;
    int failures = 0;

    // Slave configuration, written only by the main sequence while the DUT is idle.
    int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
    bit          r_never;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;

    // Slave observations, written only by the slave model.
    int          aw_fires = 0, w_fires = 0, b_fires = 0, ar_fires = 0, r_fires = 0, viol = 0;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
    logic [3:0]  seen_wstrb;

    // Per-transaction history recorded by run_txn; bit k is cycle k after command acceptance.
    logic [63:0] hist_aw, hist_w, hist_br, hist_ar, hist_rr;
    int          rsp_cycle;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    int          base_aw, base_w, base_b, base_ar, base_r, base_viol;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rready(m_axi_rready)
    );

    // Slave: ready rises after <lat> cycles of valid; responses follow after <lat> cycles.
    initial begin : slave_model
        int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit   got_aw, got_w, b_pend, r_pend;
        bit   aw_fire, w_fire, b_fire, ar_fire, r_fire;
        logic prev_awv, prev_wv, prev_arv, prev_br, prev_rr;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0;  m_axi_bresp = '0;
        m_axi_rvalid = 1'b0;  m_axi_rdata = '0;   m_axi_rresp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                prev_awv = 0; prev_wv = 0; prev_arv = 0; prev_br = 0; prev_rr = 0;
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
                m_axi_bvalid = 1'b0;  m_axi_rvalid = 1'b0;
                continue;
            end
            if (prev_awv && !aw_fire && !m_axi_awvalid) viol++;
            if (prev_wv && !w_fire && !m_axi_wvalid) viol++;
            if (prev_arv && !ar_fire && !m_axi_arvalid) viol++;
            if (aw_fire) begin aw_fires++; got_aw = 1; end
            if (w_fire) begin w_fires++; got_w = 1; end
            if (got_aw && got_w) begin b_pend = 1; b_cnt = 0; got_aw = 0; got_w = 0; end
            if (b_fire) begin b_fires++; b_pend = 0; end
            else if (prev_br && !m_axi_bready) b_pend = 0;
            if (ar_fire) begin ar_fires++; r_pend = 1; r_cnt = 0; end
            if (r_fire) begin r_fires++; r_pend = 0; end
            else if (prev_rr && !m_axi_rready) r_pend = 0;

            m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_lat);
            aw_cnt = (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            m_axi_wready = m_axi_wvalid && (w_cnt >= w_lat);
            w_cnt = (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
            m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_lat);
            ar_cnt = (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            m_axi_bvalid = b_pend && (b_cnt >= b_lat);
            if (b_pend && !m_axi_bvalid) b_cnt++;
            m_axi_bresp = m_axi_bvalid ? cfg_bresp : 2'b00;
            m_axi_rvalid = r_pend && !r_never && (r_cnt >= r_lat);
            if (r_pend && !m_axi_rvalid) r_cnt++;
            m_axi_rdata = m_axi_rvalid ? cfg_rdata : 32'd0;
            m_axi_rresp = m_axi_rvalid ? cfg_rresp : 2'b00;

            aw_fire = m_axi_awvalid && m_axi_awready;
            w_fire  = m_axi_wvalid && m_axi_wready;
            ar_fire = m_axi_arvalid && m_axi_arready;
            b_fire  = m_axi_bvalid && m_axi_bready;
            r_fire  = m_axi_rvalid && m_axi_rready;
            if (aw_fire) seen_awaddr = m_axi_awaddr;
            if (w_fire) begin seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; end
            if (ar_fire) seen_araddr = m_axi_araddr;
            prev_awv = m_axi_awvalid; prev_wv = m_axi_wvalid; prev_arv = m_axi_arvalid;
            prev_br  = m_axi_bready;  prev_rr = m_axi_rready;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_all_idle(input string tag);
        check_output({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
        check_output({tag, ".awvalid"}, 32'(m_axi_awvalid), 32'd0);
        check_output({tag, ".wvalid"}, 32'(m_axi_wvalid), 32'd0);
        check_output({tag, ".bready"}, 32'(m_axi_bready), 32'd0);
        check_output({tag, ".arvalid"}, 32'(m_axi_arvalid), 32'd0);
        check_output({tag, ".rready"}, 32'(m_axi_rready), 32'd0);
        check_output({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_output({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
        check_output({tag, ".rsp_resp"}, 32'(rsp_resp), 32'd0);
        check_output({tag, ".awaddr"}, m_axi_awaddr, 32'd0);
        check_output({tag, ".wdata"}, m_axi_wdata, 32'd0);
        check_output({tag, ".wstrb"}, 32'(m_axi_wstrb), 32'd0);
    endtask

    // Issue one command, record channel activity per cycle, hold the response, then consume it.
    task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] strb, input int hold);
        int  n;
        bit  stable;
        base_aw = aw_fires; base_w = w_fires; base_b = b_fires;
        base_ar = ar_fires; base_r = r_fires; base_viol = viol;
        hist_aw = '0; hist_w = '0; hist_br = '0; hist_ar = '0; hist_rr = '0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        check_output("cmd_accepted", 32'(cmd_ready), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            cmd_valid = 1'b0;
            hist_aw[n] = m_axi_awvalid; hist_w[n] = m_axi_wvalid; hist_br[n] = m_axi_bready;
            hist_ar[n] = m_axi_arvalid; hist_rr[n] = m_axi_rready;
        end while (!rsp_valid && n < 60);
        check_output("rsp_arrives", 32'(rsp_valid), 32'd1);
        rsp_cycle = n;
        got_rdata = rsp_rdata;
        got_resp  = rsp_resp;
        stable = 1'b1;
        repeat (hold) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata || rsp_resp !== got_resp ||
                cmd_ready !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
        end
        if (hold > 0) check_output("rsp_held_stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_output("rsp_consumed", 32'(rsp_valid), 32'd0);
        check_output("ready_after_rsp", 32'(cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    // Expected outcome from the slave configuration: writes return bresp and zero data,
    // reads return slave data, a lost response returns 2'b11 and zero data.
    task automatic check_txn(input string tag, input bit wr, input bit timed_out,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        if (timed_out) begin exp_rdata = 32'd0; exp_resp = 2'b11; end
        else if (wr)   begin exp_rdata = 32'd0; exp_resp = cfg_bresp; end
        else           begin exp_rdata = cfg_rdata; exp_resp = cfg_rresp; end
        check_output({tag, ".rdata"}, got_rdata, exp_rdata);
        check_output({tag, ".resp"}, 32'(got_resp), 32'(exp_resp));
        check_output({tag, ".viol"}, 32'(viol - base_viol), 32'd0);
        if (wr) begin
            check_output({tag, ".aw_cycles"}, 32'($countones(hist_aw)), 32'(aw_lat + 1));
            check_output({tag, ".w_cycles"}, 32'($countones(hist_w)), 32'(w_lat + 1));
            check_output({tag, ".aw_fires"}, 32'(aw_fires - base_aw), 32'd1);
            check_output({tag, ".w_fires"}, 32'(w_fires - base_w), 32'd1);
            check_output({tag, ".b_fires"}, 32'(b_fires - base_b), timed_out ? 32'd0 : 32'd1);
            check_output({tag, ".awaddr"}, seen_awaddr, addr);
            check_output({tag, ".wdata"}, seen_wdata, wd);
            check_output({tag, ".wstrb"}, 32'(seen_wstrb), 32'(strb));
        end else begin
            check_output({tag, ".ar_cycles"}, 32'($countones(hist_ar)), 32'(ar_lat + 1));
            check_output({tag, ".ar_fires"}, 32'(ar_fires - base_ar), 32'd1);
            check_output({tag, ".r_fires"}, 32'(r_fires - base_r), timed_out ? 32'd0 : 32'd1);
            check_output({tag, ".araddr"}, seen_araddr, addr);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main_seq
        bit          wr;
        logic [31:0] addr, wd;
        logic [3:0]  strb;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0;
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0; r_never = 1'b0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;

        repeat (3) @(negedge clk);
        check_all_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_output("idle.cmd_ready", 32'(cmd_ready), 32'd1);

        // Write: awready immediate, wready one cycle later.
        aw_lat = 0; w_lat = 1; b_lat = 0; cfg_bresp = 2'b00;
        apply_stimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        check_txn("wr_basic", 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check_output("wr_basic.aw_c1", 32'(hist_aw[1]), 32'd1);
        check_output("wr_basic.aw_c2", 32'(hist_aw[2]), 32'd0);
        check_output("wr_basic.w_c2", 32'(hist_w[2]), 32'd1);
        check_output("wr_basic.w_c3", 32'(hist_w[3]), 32'd0);
        check_output("wr_basic.br_c2", 32'(hist_br[2]), 32'd0);
        check_output("wr_basic.br_c3", 32'(hist_br[3]), 32'd1);
        check_output("wr_basic.rsp_cycle", 32'(rsp_cycle), 32'd4);

        // Read with the response held off for five cycles.
        ar_lat = 0; r_lat = 1; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
        apply_stimulus(1'b0, 32'h0000_0020, 32'd0, 4'h0, 5);
        check_txn("rd_basic", 1'b0, 1'b0, 32'h0000_0020, 32'd0, 4'h0);
        check_output("rd_basic.ar_c2", 32'(hist_ar[2]), 32'd0);

        // Write with W accepted three cycles before AW.
        aw_lat = 3; w_lat = 0; b_lat = 1; cfg_bresp = 2'b10;
        apply_stimulus(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h5, 1);
        check_txn("wr_skew", 1'b1, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 4'h5);

        // Read whose data never arrives.
        aw_lat = 0; ar_lat = 0; r_never = 1'b1;
        apply_stimulus(1'b0, 32'h0000_0080, 32'd0, 4'h0, 0);
        check_txn("rd_timeout", 1'b0, 1'b1, 32'h0000_0080, 32'd0, 4'h0);
        check_output("rd_timeout.rready_cycles", 32'($countones(hist_rr)), 32'(TO));
        check_output("rd_timeout.rsp_cycle", 32'(rsp_cycle), 32'(TO + 2));
        r_never = 1'b0;

        // Reset while AW is still waiting for awready.
        aw_lat = 20; w_lat = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'h3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_output("mid_wr.awvalid", 32'(m_axi_awvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_idle("mid_wr_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        aw_lat = 1; w_lat = 2; b_lat = 0; cfg_bresp = 2'b00;
        apply_stimulus(1'b1, 32'h0000_0104, 32'h0BAD_F00D, 4'hC, 0);
        check_txn("after_reset", 1'b1, 1'b0, 32'h0000_0104, 32'h0BAD_F00D, 4'hC);

        // Randomized commands and slave timing.
        for (int i = 0; i < 20; i++) begin
            wr        = 1'($urandom_range(0, 1));
            addr      = $urandom;
            wd        = $urandom;
            strb      = 4'($urandom);
            aw_lat    = $urandom_range(0, 3);
            w_lat     = $urandom_range(0, 3);
            b_lat     = $urandom_range(0, 3);
            ar_lat    = $urandom_range(0, 3);
            r_lat     = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom);
            cfg_rresp = 2'($urandom);
            cfg_rdata = $urandom;
            apply_stimulus(wr, addr, wd, strb, $urandom_range(0, 2));
            check_txn($sformatf("rand%0d", i), wr, 1'b0, addr, wd, strb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
